// File: rtl/shot_judge_if.sv
// Signal bundle between the crosshair/input logic, the duck sprite and shot_judge.
// The master side drives the player and duck inputs; shot_judge is the slave.
interface shot_judge_if;
  logic        frame_clk;
  logic        trigger;
  logic        reload;
  logic [9:0]  cross_x;
  logic [9:0]  cross_y;
  logic [18:0] duck_center;
  logic        duck_dead;
  logic        kill;
  logic        flash;
  logic        busy;
  logic [1:0]  shots_left;
  logic [7:0]  hit_count;

  modport master (
    output frame_clk, trigger, reload, cross_x, cross_y, duck_center, duck_dead,
    input  kill, flash, busy, shots_left, hit_count
  );

  modport slave (
    input  frame_clk, trigger, reload, cross_x, cross_y, duck_center, duck_dead,
    output kill, flash, busy, shots_left, hit_count
  );
endinterface

// File: rtl/shot_judge.sv
// Shot resolution for the duck game: flash, judge and cooldown phases per shot,
// a one-cycle kill pulse on a hit, ammo tracking and a saturating hit tally.
module shot_judge #(
  parameter int SHOTS           = 3,
  parameter int FLASH_FRAMES    = 2,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int HIT_RADIUS      = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  shot_judge_if.slave bus
);

  localparam int MAX_FRAMES = (FLASH_FRAMES > COOLDOWN_FRAMES) ? FLASH_FRAMES : COOLDOWN_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
  localparam logic [1:0] SHOTS_FULL = 2'(SHOTS);

  typedef enum logic [1:0] {IDLE, FLASH, JUDGE, COOLDOWN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       shots_q, shots_d;
  logic [7:0]       hits_q, hits_d;
  logic             kill_q, kill_d;
  logic             flash_q, flash_d;
  logic             busy_q, busy_d;
  logic [2:0]       trig_sync_q, frame_sync_q;
  logic             trig_edge, frame_edge, capture;

  logic [9:0]         cross_x_q, cross_y_q, duck_x_q;
  logic [8:0]         duck_y_q;
  logic               dead_q;
  logic signed [10:0] dx, dy;
  logic [10:0]        adx, ady;
  logic               hit;

  // Bit 0/1 form the synchronizer, bit 2 is the history register for edge detection.
  assign trig_edge  = trig_sync_q[1] & ~trig_sync_q[2];
  assign frame_edge = frame_sync_q[1] & ~frame_sync_q[2];

  assign dx  = $signed({1'b0, cross_x_q}) - $signed({1'b0, duck_x_q});
  assign dy  = $signed({1'b0, cross_y_q}) - $signed({2'b00, duck_y_q});
  assign adx = dx[10] ? $unsigned(-dx) : $unsigned(dx);
  assign ady = dy[10] ? $unsigned(-dy) : $unsigned(dy);
  assign hit = (adx <= 11'(HIT_RADIUS)) & (ady <= 11'(HIT_RADIUS)) & ~dead_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    shots_d = shots_q;
    hits_d  = hits_q;
    kill_d  = 1'b0;
    capture = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (trig_edge && (shots_q != 2'd0) && !bus.reload) begin
          state_d = FLASH;
          cnt_d   = '0;
          shots_d = shots_q - 2'd1;
          capture = 1'b1;
        end
      end
      FLASH: begin
        if (frame_edge) begin
          if (cnt_q == CNT_W'(FLASH_FRAMES - 1)) begin
            state_d = JUDGE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      JUDGE: begin
        state_d = COOLDOWN;
        cnt_d   = '0;
        kill_d  = hit;
        if (hit && (hits_q != 8'hFF)) hits_d = hits_q + 8'd1;
      end
      COOLDOWN: begin
        if (frame_edge) begin
          if (cnt_q == CNT_W'(COOLDOWN_FRAMES - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Reload refills ammo in any state and, in IDLE, suppresses a coincident trigger.
    if (bus.reload) shots_d = SHOTS_FULL;

    flash_d = (state_d == FLASH);
    busy_d  = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shots_q      <= SHOTS_FULL;
      hits_q       <= '0;
      kill_q       <= 1'b0;
      flash_q      <= 1'b0;
      busy_q       <= 1'b0;
      trig_sync_q  <= '0;
      frame_sync_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shots_q      <= shots_d;
      hits_q       <= hits_d;
      kill_q       <= kill_d;
      flash_q      <= flash_d;
      busy_q       <= busy_d;
      trig_sync_q  <= {trig_sync_q[1:0], bus.trigger};
      frame_sync_q <= {frame_sync_q[1:0], bus.frame_clk};
    end
  end

  // NOTE: the shot snapshot carries no reset; it is always written before JUDGE reads it.
  always_ff @(posedge Clk) begin
    if (capture) begin
      cross_x_q <= bus.cross_x;
      cross_y_q <= bus.cross_y;
      duck_x_q  <= bus.duck_center[18:9];
      duck_y_q  <= bus.duck_center[8:0];
      dead_q    <= bus.duck_dead;
    end
  end

  assign bus.kill       = kill_q;
  assign bus.flash      = flash_q;
  assign bus.busy       = busy_q;
  assign bus.shots_left = shots_q;
  assign bus.hit_count  = hits_q;

endmodule

// File: tb/tb_shot_judge.sv
// Self-checking bench for shot_judge: per-shot expectations go into a scoreboard
// queue when the trigger is driven and are popped once the shot has finished.
module tb_shot_judge;
  localparam int SHOTS           = 3;
  localparam int FLASH_FRAMES    = 2;
  localparam int COOLDOWN_FRAMES = 4;
  localparam int HIT_RADIUS      = 16;

  logic Clk = 1'b0;
  logic Reset;

  shot_judge_if bus ();

  shot_judge #(
    .SHOTS          (SHOTS),
    .FLASH_FRAMES   (FLASH_FRAMES),
    .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
    .HIT_RADIUS     (HIT_RADIUS)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    bit kill;
    int hits;
    int shots;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   model_hits = 0;
  int   model_shots = SHOTS;
  int   kill_total = 0;

  always @(negedge Clk) if (bus.kill === 1'b1) kill_total++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic frame();
    bus.frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    bus.frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic pulse_trigger();
    bus.trigger = 1'b1;
    repeat (3) @(negedge Clk);
    bus.trigger = 1'b0;
  endtask

  task automatic wait_busy(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (bus.busy === 1'b1) seen = 1'b1;
      else @(negedge Clk);
    end
  endtask

  task automatic do_reload();
    bus.reload = 1'b1;
    @(negedge Clk);
    bus.reload = 1'b0;
    model_shots = SHOTS;
    total++;
    if (bus.shots_left !== 2'(SHOTS)) begin
      bad++;
      $display("FAIL reload_shots: got %0d expected %0d", bus.shots_left, SHOTS);
    end
  endtask

  task automatic fire_shot(input int cx, input int cy, input int x, input int y,
                           input bit dead, input bit extra_trig, input bit check_timing);
    exp_t e;
    int   k0, fl_frames, frames;
    bit   seen, late_busy;
    if (model_shots == 0) do_reload();
    bus.cross_x     = 10'(cx);
    bus.cross_y     = 10'(cy);
    bus.duck_center = {10'(x), 9'(y)};
    bus.duck_dead   = dead;
    e.kill  = !dead && (iabs(cx - x) <= HIT_RADIUS) && (iabs(cy - y) <= HIT_RADIUS);
    e.hits  = (model_hits + int'(e.kill) > 255) ? 255 : model_hits + int'(e.kill);
    e.shots = model_shots - 1;
    sb.push_back(e);
    k0 = kill_total;

    pulse_trigger();
    wait_busy(seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL shot_start: busy=%b expected 1", bus.busy);
    end
    total++;
    if (bus.flash !== 1'b1) begin
      bad++;
      $display("FAIL shot_flash: flash=%b expected 1", bus.flash);
    end

    fl_frames = 0;
    frames    = 0;
    while (bus.busy === 1'b1 && frames < 12) begin
      if (extra_trig && (frames == 0 || frames == 3)) pulse_trigger();
      if (bus.flash === 1'b1) fl_frames++;
      frame();
      frames++;
    end

    e = sb.pop_front();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL shot_end: busy=%b expected 0 after %0d frames", bus.busy, frames);
    end
    total++;
    if ((kill_total - k0) != int'(e.kill)) begin
      bad++;
      $display("FAIL kill_pulses: got %0d cycles expected %0d", kill_total - k0, int'(e.kill));
    end
    total++;
    if (bus.hit_count !== 8'(e.hits)) begin
      bad++;
      $display("FAIL hit_count: got %0d expected %0d", bus.hit_count, e.hits);
    end
    total++;
    if (bus.shots_left !== 2'(e.shots)) begin
      bad++;
      $display("FAIL shots_left: got %0d expected %0d", bus.shots_left, e.shots);
    end
    if (check_timing) begin
      total++;
      if (fl_frames != FLASH_FRAMES) begin
        bad++;
        $display("FAIL flash_frames: got %0d expected %0d", fl_frames, FLASH_FRAMES);
      end
      total++;
      if (frames != FLASH_FRAMES + COOLDOWN_FRAMES) begin
        bad++;
        $display("FAIL busy_frames: got %0d expected %0d", frames, FLASH_FRAMES + COOLDOWN_FRAMES);
      end
    end
    if (extra_trig) begin
      late_busy = 1'b0;
      repeat (10) begin
        @(negedge Clk);
        if (bus.busy === 1'b1) late_busy = 1'b1;
      end
      total++;
      if (late_busy) begin
        bad++;
        $display("FAIL queued_trigger: busy rose after shot, expected 0");
      end
    end
    model_hits  = e.hits;
    model_shots = e.shots;
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (bus.kill !== 1'b0)         begin bad++; $display("FAIL %s_kill: got %b expected 0", tag, bus.kill); end
    total++;
    if (bus.flash !== 1'b0)        begin bad++; $display("FAIL %s_flash: got %b expected 0", tag, bus.flash); end
    total++;
    if (bus.busy !== 1'b0)         begin bad++; $display("FAIL %s_busy: got %b expected 0", tag, bus.busy); end
    total++;
    if (bus.shots_left !== 2'(SHOTS)) begin bad++; $display("FAIL %s_shots: got %0d expected %0d", tag, bus.shots_left, SHOTS); end
    total++;
    if (bus.hit_count !== 8'd0)    begin bad++; $display("FAIL %s_hits: got %0d expected 0", tag, bus.hit_count); end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    bus.frame_clk = 1'b0;
    bus.trigger = 1'b0;
    bus.reload = 1'b0;
    bus.cross_x = '0;
    bus.cross_y = '0;
    bus.duck_center = '0;
    bus.duck_dead = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check_reset_outputs("reset");
  endtask

  task automatic test_hit();
    fire_shot(330, 230, 320, 240, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_boundary();
    int tbl [4][2] = '{'{116, 84}, '{117, 100}, '{84, 116}, '{100, 83}};
    foreach (tbl[i]) fire_shot(tbl[i][0], tbl[i][1], 100, 100, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_dead_duck();
    fire_shot(200, 150, 200, 150, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_ammo();
    bit rose;
    if (model_shots != SHOTS) do_reload();
    repeat (3) fire_shot(0, 0, 300, 300, 1'b0, 1'b0, 1'b0);
    pulse_trigger();
    rose = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      if (bus.busy === 1'b1) rose = 1'b1;
    end
    total++;
    if (rose) begin bad++; $display("FAIL empty_trigger: busy rose with no ammo, expected 0"); end
    total++;
    if (bus.shots_left !== 2'd0) begin bad++; $display("FAIL empty_shots: got %0d expected 0", bus.shots_left); end

    do_reload();
    repeat (2) fire_shot(0, 0, 300, 300, 1'b0, 1'b0, 1'b0);

    bus.trigger = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    bus.reload = 1'b1;
    @(negedge Clk);
    bus.reload = 1'b0;
    model_shots = SHOTS;
    rose = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      if (bus.busy === 1'b1) rose = 1'b1;
    end
    bus.trigger = 1'b0;
    repeat (4) @(negedge Clk);
    total++;
    if (rose) begin bad++; $display("FAIL reload_vs_trigger: busy rose, expected 0"); end
    total++;
    if (bus.shots_left !== 2'(SHOTS)) begin
      bad++;
      $display("FAIL reload_vs_trigger_shots: got %0d expected %0d", bus.shots_left, SHOTS);
    end
  endtask

  task automatic test_mid_shot_triggers();
    fire_shot(330, 230, 320, 240, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_in_flash();
    bit seen;
    int k0;
    bus.cross_x = 10'd320;
    bus.cross_y = 10'd240;
    bus.duck_center = {10'd320, 9'd240};
    bus.duck_dead = 1'b0;
    pulse_trigger();
    wait_busy(seen);
    total++;
    if (!seen || bus.flash !== 1'b1) begin
      bad++;
      $display("FAIL reset_flash_start: flash=%b expected 1", bus.flash);
    end
    Reset = 1'b0;
    @(negedge Clk);
    model_hits = 0;
    model_shots = SHOTS;
    check_reset_outputs("midflash");
    Reset = 1'b1;
    k0 = kill_total;
    repeat (8) frame();
    total++;
    if (kill_total != k0) begin bad++; $display("FAIL abort_kill: got %0d pulses expected 0", kill_total - k0); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 256; i++) fire_shot(320, 240, 320, 240, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.hit_count !== 8'd255) begin
      bad++;
      $display("FAIL saturation: got %0d expected 255", bus.hit_count);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_boundary();
    test_dead_duck();
    test_ammo();
    test_mid_shot_triggers();
    test_reset_in_flash();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
